// File: rtl/ser_tx_scheduler.sv
// Round-robin scheduler sharing one serializer among NUM_REQ frame sources.
// It enforces an inter-frame gap and traps hung transfers in FAULT via a WAIT watchdog.
module ser_tx_scheduler #(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned DATA_DEPTH = 4,
  parameter int unsigned GAP_WIDTH  = 8,
  parameter int unsigned TO_WIDTH   = 16
) (
  input  logic                                      clk,
  input  logic                                      rst_n,
  input  logic [NUM_REQ-1:0]                        req,
  input  logic [NUM_REQ*DATA_DEPTH*DATA_WIDTH-1:0]  req_data,
  input  logic [NUM_REQ*($clog2(DATA_WIDTH)+1)-1:0] req_width,
  input  logic [NUM_REQ*($clog2(DATA_DEPTH)+1)-1:0] req_depth,
  input  logic [GAP_WIDTH-1:0]                      gap_cycles,
  input  logic [TO_WIDTH-1:0]                       timeout,
  input  logic                                      clr_fault,
  output logic [NUM_REQ-1:0]                        ack,
  output logic                                      err,
  output logic                                      fault,
  output logic                                      busy,
  output logic [$clog2(NUM_REQ)-1:0]                grant_id,
  output logic                                      ser_start,
  output logic [DATA_DEPTH*DATA_WIDTH-1:0]          ser_par_in,
  output logic [$clog2(DATA_WIDTH):0]               ser_width,
  output logic [$clog2(DATA_DEPTH):0]               ser_depth,
  input  logic                                      ser_done
);

  localparam int unsigned ID_W    = $clog2(NUM_REQ);
  localparam int unsigned FRAME_W = DATA_DEPTH * DATA_WIDTH;
  localparam int unsigned WW      = $clog2(DATA_WIDTH) + 1;
  localparam int unsigned DW      = $clog2(DATA_DEPTH) + 1;

  typedef enum logic [2:0] {S_IDLE, S_START, S_WAIT, S_GAP, S_FAULT} state_t;

  state_t               state_q, state_d;
  logic [ID_W-1:0]      last_grant_q, last_grant_d;
  logic [ID_W-1:0]      grant_q, grant_d;
  logic [FRAME_W-1:0]   par_q, par_d;
  logic [WW-1:0]        width_q, width_d;
  logic [DW-1:0]        depth_q, depth_d;
  logic [TO_WIDTH-1:0]  timer_q, timer_d;
  logic [GAP_WIDTH-1:0] gap_cnt_q, gap_cnt_d;
  logic [NUM_REQ-1:0]   ack_q, ack_d;
  logic                 err_q, err_d;
  logic                 fault_q, fault_d;
  logic                 busy_q, busy_d;
  logic                 start_q, start_d;

  logic                 found;
  logic [ID_W-1:0]      win;
  int unsigned          idx;

  // State and output registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      last_grant_q <= ID_W'(NUM_REQ - 1);
      grant_q      <= '0;
      par_q        <= '0;
      width_q      <= '0;
      depth_q      <= '0;
      timer_q      <= '0;
      gap_cnt_q    <= '0;
      ack_q        <= '0;
      err_q        <= 1'b0;
      fault_q      <= 1'b0;
      busy_q       <= 1'b0;
      start_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      grant_q      <= grant_d;
      par_q        <= par_d;
      width_q      <= width_d;
      depth_q      <= depth_d;
      timer_q      <= timer_d;
      gap_cnt_q    <= gap_cnt_d;
      ack_q        <= ack_d;
      err_q        <= err_d;
      fault_q      <= fault_d;
      busy_q       <= busy_d;
      start_q      <= start_d;
    end
  end

  // Next-state, arbitration and registered-output decode
  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    grant_d      = grant_q;
    par_d        = par_q;
    width_d      = width_q;
    depth_d      = depth_q;
    timer_d      = timer_q;
    gap_cnt_d    = gap_cnt_q;
    ack_d        = '0;
    err_d        = 1'b0;
    start_d      = 1'b0;
    found        = 1'b0;
    win          = '0;
    idx          = 0;

    // First set req scanning upward from last_grant+1, wrapping
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      idx = (32'(last_grant_q) + k) % NUM_REQ;
      if (!found && req[idx]) begin
        found = 1'b1;
        win   = ID_W'(idx);
      end
    end

    unique case (state_q)
      S_IDLE: begin
        if (found) begin
          state_d      = S_START;
          grant_d      = win;
          last_grant_d = win;
          par_d        = req_data[32'(win)*FRAME_W +: FRAME_W];
          width_d      = req_width[32'(win)*WW +: WW];
          depth_d      = req_depth[32'(win)*DW +: DW];
          start_d      = 1'b1;
        end
      end
      S_START: begin
        timer_d = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        timer_d = timer_q + TO_WIDTH'(1);
        // done takes priority over a coincident watchdog expiry
        if (ser_done) begin
          ack_d[grant_q] = 1'b1;
          state_d        = S_GAP;
          gap_cnt_d      = (gap_cycles == '0) ? '0 : gap_cycles - GAP_WIDTH'(1);
        end else if ((timeout != '0) && (timer_q == timeout)) begin
          err_d   = 1'b1;
          state_d = S_FAULT;
        end
      end
      S_GAP: begin
        if (gap_cnt_q == '0) state_d = S_IDLE;
        else                 gap_cnt_d = gap_cnt_q - GAP_WIDTH'(1);
      end
      S_FAULT: begin
        if (clr_fault) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    fault_d = (state_d == S_FAULT);
    busy_d  = (state_d != S_IDLE);
  end

  assign ack        = ack_q;
  assign err        = err_q;
  assign fault      = fault_q;
  assign busy       = busy_q;
  assign grant_id   = grant_q;
  assign ser_start  = start_q;
  assign ser_par_in = par_q;
  assign ser_width  = width_q;
  assign ser_depth  = depth_q;

endmodule

// File: tb/tb_ser_tx_scheduler.sv
// Self-checking bench for ser_tx_scheduler: scenario tasks plus randomized frames
// checked against a round-robin / gap / watchdog model kept in the bench.
module tb_ser_tx_scheduler;

  localparam int unsigned NUM_REQ    = 4;
  localparam int unsigned DATA_WIDTH = 32;
  localparam int unsigned DATA_DEPTH = 4;
  localparam int unsigned GAP_WIDTH  = 8;
  localparam int unsigned TO_WIDTH   = 16;
  localparam int unsigned ID_W       = 2;
  localparam int unsigned FRAME_W    = DATA_DEPTH * DATA_WIDTH;
  localparam int unsigned WW         = 6;
  localparam int unsigned DW         = 3;
  localparam int unsigned RW_W       = NUM_REQ * WW;
  localparam int unsigned RD_W       = NUM_REQ * DW;

  logic                         clk = 1'b0;
  logic                         rst_n;
  logic [NUM_REQ-1:0]           req;
  logic [NUM_REQ*FRAME_W-1:0]   req_data;
  logic [RW_W-1:0]              req_width;
  logic [RD_W-1:0]              req_depth;
  logic [GAP_WIDTH-1:0]         gap_cycles;
  logic [TO_WIDTH-1:0]          timeout;
  logic                         clr_fault;
  logic [NUM_REQ-1:0]           ack;
  logic                         err;
  logic                         fault;
  logic                         busy;
  logic [ID_W-1:0]              grant_id;
  logic                         ser_start;
  logic [FRAME_W-1:0]           ser_par_in;
  logic [WW-1:0]                ser_width;
  logic [DW-1:0]                ser_depth;
  logic                         ser_done;

  int tests  = 0;
  int failed = 0;
  int last_g = NUM_REQ - 1;

  always #5 clk = ~clk;

  ser_tx_scheduler #(
    .NUM_REQ(NUM_REQ), .DATA_WIDTH(DATA_WIDTH), .DATA_DEPTH(DATA_DEPTH),
    .GAP_WIDTH(GAP_WIDTH), .TO_WIDTH(TO_WIDTH)
  ) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .req_data(req_data),
    .req_width(req_width), .req_depth(req_depth), .gap_cycles(gap_cycles),
    .timeout(timeout), .clr_fault(clr_fault), .ack(ack), .err(err),
    .fault(fault), .busy(busy), .grant_id(grant_id), .ser_start(ser_start),
    .ser_par_in(ser_par_in), .ser_width(ser_width), .ser_depth(ser_depth),
    .ser_done(ser_done)
  );

  // Round-robin rule: first requester after the last grant, wrapping
  function automatic int rr_pick(input logic [NUM_REQ-1:0] r, input int last);
    for (int k = 1; k <= NUM_REQ; k++)
      if (r[(last + k) % NUM_REQ]) return (last + k) % NUM_REQ;
    return -1;
  endfunction

  function automatic int gap_len(input int g);
    return (g == 0) ? 1 : g;
  endfunction

  task automatic randomize_frames();
    for (int i = 0; i < NUM_REQ * FRAME_W / 32; i++) req_data[i*32 +: 32] = $urandom;
    req_width = RW_W'($urandom);
    req_depth = RD_W'($urandom);
  endtask

  // Bench-side serializer: waits for start, raises done after 'delay' cycles,
  // and reports what the scheduler showed along the way.
  task automatic serve_frame(input int delay, input logic [NUM_REQ-1:0] req_after,
                             output bit ok, output int wt, output int g,
                             output logic [FRAME_W-1:0] par, output logic [WW-1:0] w,
                             output logic [DW-1:0] d, output bit twice,
                             output logic [NUM_REQ-1:0] ack_obs, output logic err_obs,
                             output logic [NUM_REQ-1:0] ack_next, output int busy_len);
    ok = 0; wt = 0; g = -1; par = 'x; w = 'x; d = 'x; twice = 0;
    ack_obs = 'x; err_obs = 1'bx; ack_next = 'x; busy_len = 0;
    for (int i = 0; i < 60 && !ok; i++) begin
      @(negedge clk);
      wt = i + 1;
      if (ser_start === 1'b1) ok = 1;
    end
    if (!ok) return;
    g = int'(grant_id); par = ser_par_in; w = ser_width; d = ser_depth;
    @(negedge clk);
    twice = (ser_start === 1'b1);
    repeat (delay - 1) @(negedge clk);
    ser_done = 1'b1;
    @(negedge clk);
    ser_done = 1'b0;
    ack_obs = ack; err_obs = err; req = req_after;
    for (int i = 0; i < 300 && busy === 1'b1; i++) begin
      busy_len++;
      @(negedge clk);
      if (i == 0) ack_next = ack;
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; req = '1; ser_done = 1'b1; clr_fault = 1'b1; timeout = 16'd3;
    @(negedge clk); @(negedge clk);
    tests++; if ({ack, err, fault, busy, ser_start} !== 8'h00) begin
      failed++; $display("FAIL reset_ctrl: got %b want 00000000", {ack, err, fault, busy, ser_start}); end
    tests++; if ({grant_id, ser_width, ser_depth} !== 11'h0 || ser_par_in !== '0) begin
      failed++; $display("FAIL reset_data: got id=%0d w=%0d d=%0d par=%h want all 0", grant_id, ser_width, ser_depth, ser_par_in); end
    req = '0; ser_done = 1'b0; clr_fault = 1'b0; timeout = '0; rst_n = 1'b1;
    last_g = NUM_REQ - 1;
    @(negedge clk);
    tests++; if ({busy, ser_start, fault} !== 3'b000) begin
      failed++; $display("FAIL reset_idle: got busy/start/fault=%b want 000", {busy, ser_start, fault}); end
  endtask

  task automatic test_single();
    bit ok, tw; int wt, g, bl, e; logic [FRAME_W-1:0] par, xp;
    logic [WW-1:0] w; logic [DW-1:0] d; logic [NUM_REQ-1:0] ao, an; logic eo;
    gap_cycles = 8'd2; randomize_frames();
    req_width[2*WW +: WW] = 6'd7; req_depth[2*DW +: DW] = 3'd0; req = 4'b0100;
    e = rr_pick(req, last_g); xp = req_data[e*FRAME_W +: FRAME_W];
    serve_frame(3, '0, ok, wt, g, par, w, d, tw, ao, eo, an, bl);
    last_g = e;
    tests++; if (!ok) begin failed++; $display("FAIL single_start: no ser_start within 60 cycles"); end
    tests++; if (g !== 2) begin failed++; $display("FAIL single_grant: got %0d want 2", g); end
    tests++; if (wt !== 1) begin failed++; $display("FAIL single_latency: got %0d want 1", wt); end
    tests++; if (par !== xp) begin failed++; $display("FAIL single_par: got %h want %h", par, xp); end
    tests++; if (w !== 6'd7 || d !== 3'd0) begin failed++; $display("FAIL single_shape: got w=%0d d=%0d want 7 0", w, d); end
    tests++; if (tw !== 1'b0) begin failed++; $display("FAIL single_start_len: got 2+ cycles want 1"); end
    tests++; if (ao !== 4'b0100 || eo !== 1'b0) begin failed++; $display("FAIL single_ack: got ack=%b err=%b want 0100 0", ao, eo); end
    tests++; if (an !== 4'b0000) begin failed++; $display("FAIL single_ack_len: got %b want 0000", an); end
    tests++; if (bl !== 2 || busy !== 1'b0) begin failed++; $display("FAIL single_gap: got %0d busy=%b want 2 0", bl, busy); end
  endtask

  task automatic test_fairness();
    bit ok, tw; int wt, g, bl, e, gp; logic [FRAME_W-1:0] par;
    logic [WW-1:0] w; logic [DW-1:0] d; logic [NUM_REQ-1:0] ao, an; logic eo;
    int ack_cnt [NUM_REQ];
    for (int i = 0; i < NUM_REQ; i++) ack_cnt[i] = 0;
    rst_n = 1'b0; @(negedge clk); rst_n = 1'b1; last_g = NUM_REQ - 1;
    req = '1;
    for (int f = 0; f < 8; f++) begin
      gp = $urandom_range(0, 3); gap_cycles = GAP_WIDTH'(gp);
      e = rr_pick(req, last_g);
      serve_frame($urandom_range(1, 6), '1, ok, wt, g, par, w, d, tw, ao, eo, an, bl);
      last_g = e;
      for (int i = 0; i < NUM_REQ; i++) if (ao[i] === 1'b1) ack_cnt[i]++;
      tests++; if (!ok || g !== f % NUM_REQ || g !== e) begin
        failed++; $display("FAIL fair_grant[%0d]: got %0d want %0d", f, g, f % NUM_REQ); end
      tests++; if (bl !== gap_len(gp)) begin failed++; $display("FAIL fair_gap[%0d]: got %0d want %0d", f, bl, gap_len(gp)); end
    end
    req = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      tests++; if (ack_cnt[i] !== 2) begin failed++; $display("FAIL fair_acks[%0d]: got %0d want 2", i, ack_cnt[i]); end
    end
  endtask

  task automatic test_timeout();
    bit ok, tw, seen, ack_any; int wt, g, bl, e, k, errs, starts; logic [FRAME_W-1:0] par;
    logic [WW-1:0] w; logic [DW-1:0] d; logic [NUM_REQ-1:0] ao, an; logic eo;
    timeout = 16'd20; gap_cycles = 8'd1; randomize_frames();
    req = NUM_REQ'($urandom_range(1, 15));
    e = rr_pick(req, last_g);
    ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin @(negedge clk); if (ser_start === 1'b1) ok = 1; end
    tests++; if (!ok || int'(grant_id) !== e) begin failed++; $display("FAIL to_grant: got ok=%0d id=%0d want 1 %0d", ok, grant_id, e); end
    last_g = e;
    seen = 0; k = 0; ack_any = 0;
    for (int i = 1; i <= 100 && !seen; i++) begin
      @(negedge clk);
      if (ack !== '0) ack_any = 1;
      if (err === 1'b1) begin seen = 1; k = i; end
    end
    tests++; if (!seen || k !== 22) begin failed++; $display("FAIL to_err_time: got seen=%0d at %0d want 1 at 22", seen, k); end
    tests++; if (fault !== 1'b1 || ack_any !== 1'b0) begin failed++; $display("FAIL to_fault: got fault=%b ack_seen=%0d want 1 0", fault, ack_any); end
    req = '1; errs = 0; starts = 0;
    repeat (10) begin
      @(negedge clk);
      if (err === 1'b1) errs++;
      if (ser_start === 1'b1) starts++;
    end
    tests++; if (errs !== 0 || starts !== 0 || fault !== 1'b1 || busy !== 1'b1) begin
      failed++; $display("FAIL to_hold: got errs=%0d starts=%0d fault=%b busy=%b want 0 0 1 1", errs, starts, fault, busy); end
    clr_fault = 1'b1; @(negedge clk); clr_fault = 1'b0;
    tests++; if (fault !== 1'b0 || busy !== 1'b0) begin failed++; $display("FAIL to_clear: got fault=%b busy=%b want 0 0", fault, busy); end
    e = rr_pick(req, last_g);
    serve_frame(2, '0, ok, wt, g, par, w, d, tw, ao, eo, an, bl);
    last_g = e;
    tests++; if (!ok || g !== e || ao !== NUM_REQ'(1 << e)) begin
      failed++; $display("FAIL to_next_grant: got id=%0d ack=%b want %0d", g, ao, e); end
  endtask

  task automatic test_race();
    bit ok, tw; int wt, g, bl, e, gp, to; logic [FRAME_W-1:0] par;
    logic [WW-1:0] w; logic [DW-1:0] d; logic [NUM_REQ-1:0] ao, an; logic eo;
    to = $urandom_range(5, 30); timeout = TO_WIDTH'(to);
    gp = $urandom_range(0, 3); gap_cycles = GAP_WIDTH'(gp);
    req = NUM_REQ'($urandom_range(1, 15));
    e = rr_pick(req, last_g);
    serve_frame(to + 1, '0, ok, wt, g, par, w, d, tw, ao, eo, an, bl);
    last_g = e;
    tests++; if (!ok || ao !== NUM_REQ'(1 << e) || eo !== 1'b0) begin
      failed++; $display("FAIL race_ack: got ack=%b err=%b want %b 0", ao, eo, NUM_REQ'(1 << e)); end
    tests++; if (bl !== gap_len(gp) || fault !== 1'b0) begin
      failed++; $display("FAIL race_nofault: got busy_len=%0d fault=%b want %0d 0", bl, fault, gap_len(gp)); end
    timeout = '0;
  endtask

  task automatic test_back_to_back();
    bit ok, tw; int wt, g, bl, bl1, e; logic [FRAME_W-1:0] par;
    logic [WW-1:0] w; logic [DW-1:0] d; logic [NUM_REQ-1:0] ao, an; logic eo;
    gap_cycles = 8'd0; timeout = '0; req = 4'b0011;
    e = rr_pick(req, last_g);
    serve_frame(2, 4'b0011, ok, wt, g, par, w, d, tw, ao, eo, an, bl1);
    last_g = e;
    tests++; if (!ok || g !== e || bl1 !== 1) begin failed++; $display("FAIL b2b_first: got id=%0d gap=%0d want %0d 1", g, bl1, e); end
    e = rr_pick(req, last_g);
    serve_frame(4, '0, ok, wt, g, par, w, d, tw, ao, eo, an, bl);
    last_g = e;
    tests++; if (!ok || g !== e || ao !== NUM_REQ'(1 << e)) begin failed++; $display("FAIL b2b_second: got id=%0d ack=%b want %0d", g, ao, e); end
    tests++; if (bl1 + 1 + wt !== 3) begin failed++; $display("FAIL b2b_spacing: got %0d want 3", bl1 + 1 + wt); end
  endtask

  task automatic test_reset_in_wait();
    bit ok, tw; int wt, g, bl; logic [FRAME_W-1:0] par;
    logic [WW-1:0] w; logic [DW-1:0] d; logic [NUM_REQ-1:0] ao, an; logic eo;
    randomize_frames(); gap_cycles = 8'd1; req = 4'b0110;
    ok = 0;
    for (int i = 0; i < 60 && !ok; i++) begin @(negedge clk); if (ser_start === 1'b1) ok = 1; end
    tests++; if (!ok) begin failed++; $display("FAIL rstw_start: no ser_start within 60 cycles"); end
    repeat (3) @(negedge clk);
    rst_n = 1'b0; @(negedge clk);
    tests++; if ({ack, err, fault, busy, ser_start} !== 8'h00 || grant_id !== '0 || ser_par_in !== '0) begin
      failed++; $display("FAIL rstw_outputs: got ctrl=%b id=%0d want 0 0", {ack, err, fault, busy, ser_start}, grant_id); end
    rst_n = 1'b1; req = '1; last_g = NUM_REQ - 1;
    serve_frame(2, '0, ok, wt, g, par, w, d, tw, ao, eo, an, bl);
    last_g = 0;
    tests++; if (!ok || g !== 0 || ao !== 4'b0001) begin failed++; $display("FAIL rstw_regrant: got id=%0d ack=%b want 0 0001", g, ao); end
  endtask

  task automatic test_random();
    bit ok, tw; int wt, g, bl, e, gp; logic [FRAME_W-1:0] par, xp;
    logic [WW-1:0] w, xw; logic [DW-1:0] d, xd; logic [NUM_REQ-1:0] ao, an; logic eo;
    int bad;
    bad = 0;
    for (int f = 0; f < 40; f++) begin
      randomize_frames();
      gp = $urandom_range(0, 4); gap_cycles = GAP_WIDTH'(gp);
      timeout = ($urandom_range(0, 1) == 1) ? 16'd100 : 16'd0;
      req = NUM_REQ'($urandom_range(1, 15));
      e = rr_pick(req, last_g);
      xp = req_data[e*FRAME_W +: FRAME_W]; xw = req_width[e*WW +: WW]; xd = req_depth[e*DW +: DW];
      serve_frame($urandom_range(1, 8), NUM_REQ'($urandom), ok, wt, g, par, w, d, tw, ao, eo, an, bl);
      last_g = e;
      tests++;
      if (!ok || g !== e || par !== xp || w !== xw || d !== xd || tw !== 1'b0 ||
          ao !== NUM_REQ'(1 << e) || eo !== 1'b0 || an !== '0 || bl !== gap_len(gp)) begin
        failed++; bad++;
        $display("FAIL rand[%0d]: got id=%0d w=%0d d=%0d ack=%b err=%b gap=%0d want id=%0d w=%0d d=%0d ack=%b gap=%0d par_ok=%0d",
                 f, g, w, d, ao, eo, bl, e, xw, xd, NUM_REQ'(1 << e), gap_len(gp), par === xp);
      end
    end
    req = '0;
  endtask

  initial begin
    rst_n = 1'b0; req = '0; req_data = '0; req_width = '0; req_depth = '0;
    gap_cycles = '0; timeout = '0; clr_fault = 1'b0; ser_done = 1'b0;
    test_reset();
    test_single();
    test_fairness();
    test_timeout();
    test_race();
    test_back_to_back();
    test_reset_in_wait();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/ser_tx_scheduler.md
Name: ser_tx_scheduler

Overview:
Round-robin scheduler that shares one serializer instance between NUM_REQ frame sources. It captures the winning requester's frame and shape (width/depth), issues a single-cycle start, and waits for serializer done. It then acknowledges the requester and enforces a programmable inter-frame gap. A watchdog traps hung transfers in a FAULT state until software clears it.

Parameters:
NUM_REQ, 4, number of requesters (>=2)
DATA_WIDTH, 32, bits per sample (matches serializer)
DATA_DEPTH, 4, samples per frame (matches serializer)
GAP_WIDTH, 8, width of gap_cycles
TO_WIDTH, 16, width of timeout

Ports:
clk  in  1  clock
rst_n  in  1  reset; synchronous, active-low
req  in  NUM_REQ  per-requester request level
req_data  in  NUM_REQ*DATA_DEPTH*DATA_WIDTH  frames, requester i at slice i
req_width  in  NUM_REQ*($clog2(DATA_WIDTH)+1)  last bit index (inclusive), per requester
req_depth  in  NUM_REQ*($clog2(DATA_DEPTH)+1)  last sample index (inclusive), per requester
gap_cycles  in  GAP_WIDTH  idle cycles between frames
timeout  in  TO_WIDTH  WAIT watchdog limit; 0 disables
clr_fault  in  1  leave FAULT
ack  out  NUM_REQ  one-cycle completion pulse to granted requester
err  out  1  one-cycle timeout pulse
fault  out  1  high while in FAULT
busy  out  1  state != IDLE
grant_id  out  $clog2(NUM_REQ)  current/last granted requester
ser_start  out  1  to serializer start
ser_par_in  out  DATA_DEPTH*DATA_WIDTH  to serializer par_in
ser_width  out  $clog2(DATA_WIDTH)+1  to serializer width
ser_depth  out  $clog2(DATA_DEPTH)+1  to serializer depth
ser_done  in  1  serializer done (pulse)

Behaviour:
- Reset (rst_n low at posedge): state=IDLE. All outputs 0. Internal last_grant=NUM_REQ-1, so requester 0 has first priority. Timers=0. Reset mid-transfer aborts immediately with no ack and no err.
- States: IDLE, START, WAIT, GAP, FAULT.
- IDLE: when any req bit is set, select the first set bit scanning from last_grant+1 upward, wrapping modulo NUM_REQ.
  - Same edge: register grant_id and last_grant; capture that requester's data, width and depth into ser_par_in/ser_width/ser_depth; go to START.
  - Arbitration latency: req high at edge N means ser_start is high during cycle N+1.
- START: ser_start=1 for exactly this one cycle; clear wait timer; go to WAIT.
- ser_par_in/ser_width/ser_depth hold their values from capture until the next capture. They are never changed outside IDLE.
- WAIT: timer increments each cycle.
  - ser_done=1: pulse ack[grant_id] in the next cycle (registered), go to GAP.
  - Else if timeout!=0 and timer==timeout: pulse err next cycle, go to FAULT.
  - ser_done and timeout in the same cycle: done wins.
  - While in WAIT, only the first ser_done pulse is acted on.
- GAP: lasts max(gap_cycles,1) cycles, then go to IDLE. The minimum of 1 guarantees the serializer is back in its idle state before the next start.
- FAULT: fault=1, busy=1, no grants. clr_fault=1 returns to IDLE next cycle. clr_fault is ignored in all other states.
- ack and err are never high in the same cycle. At most one ack bit is high at a time.
- Requesters hold req and data stable until ack or err.
  - A req dropped after grant does not cancel the transfer; ack is still issued.
  - A req still high after ack is treated as a new request and competes normally.
- req bits for unselected requesters are ignored outside IDLE; no queuing beyond the req level itself.
- Round-robin fairness: with all req held high, grants cycle 0,1,2,...,NUM_REQ-1,0.
- Width/depth values pass through unchanged with no range check; out-of-range shapes are the requester's responsibility.

Test Plan:
- Single request: NUM_REQ=4, req=4'b0100, width=7, depth=0, gap=2. Expect grant_id=2, one ser_start pulse, ser_par_in equal to slice 2; bench serializer raises done; then ack=4'b0100 for exactly one cycle, busy for 2 gap cycles, then IDLE.
- Fairness: req=4'b1111 held for 8 frames. Grant order 0,1,2,3,0,1,2,3. Each requester receives exactly 2 acks.
- Timeout: timeout=20, serializer never asserts done. Expect err pulse when the timer reaches 20, fault=1, and no ack. A new req is ignored until clr_fault; the next cycle after clr_fault is IDLE, and the next grant is last_grant+1.
- Same-cycle race: ser_done asserted on the same cycle the timer equals timeout. Expect ack, no err, no fault.
- gap_cycles=0 with back-to-back req=4'b0011. Expect exactly one GAP cycle between done and the next IDLE, and the second ser_start at least 3 cycles after ser_done.
- Reset in WAIT: assert rst_n=0 for one edge mid-frame. Next cycle: all outputs 0, state IDLE, no ack or err. A req then held on requester 0 is granted first.
